// File: rtl/conv3x3_engine_pkg.sv
// Shared codes, tile/kernel geometry and arithmetic widths for the 3x3 convolution engine.
package conv_pkg;

  typedef enum logic [2:0] {
    MS_IDLE  = 3'd0,
    MS_LOAD  = 3'd1,
    MS_STORE = 3'd2
  } ms_e;

  typedef enum logic [2:0] {
    CS_IDLE = 3'd0,
    CS_DONE = 3'd1,
    CS_BUSY = 3'd2
  } cs_e;

  localparam int TILE_DIM = 4;
  localparam int KER_DIM  = 3;
  localparam int OUT_DIM  = 2;
  localparam int NUM_PIX  = TILE_DIM * TILE_DIM;
  localparam int NUM_WGT  = KER_DIM * KER_DIM;
  localparam int NUM_OUT  = OUT_DIM * OUT_DIM;
  localparam int PROD_W   = 17;
  localparam int ACC_W    = 21;
  localparam int SUM_W    = 23;

  // Tile pixel feeding output j at kernel tap k: p((y+kr)*4 + (x+kc)).
  function automatic logic [3:0] pix_idx(input logic [1:0] j, input logic [3:0] k);
    int kr, kc;
    kr = int'(k) / KER_DIM;
    kc = int'(k) % KER_DIM;
    return 4'((int'(j[1]) + kr) * TILE_DIM + int'(j[0]) + kc);
  endfunction

endpackage

// File: rtl/conv3x3_engine_if.sv
// Memory <-> engine bus: status codes, operand tile/kernel and packed results.
interface conv3x3_engine_if #(
  parameter int PIX_W = 8,
  parameter int WGT_W = 8,
  parameter int RES_W = 32
);
  logic [2:0]          state;
  logic [16*PIX_W-1:0] DATA;
  logic [9*WGT_W-1:0]  FILTER;
  logic [2:0]          CS;
  logic [RES_W-1:0]    ret22;
  logic [RES_W-1:0]    ret33;

  modport master (output state, DATA, FILTER, input CS, ret22, ret33);
  modport slave  (input state, DATA, FILTER, output CS, ret22, ret33);
endinterface

// File: rtl/conv3x3_engine_mac_unit.sv
// Unsigned-pixel x signed-weight MAC; acc_nxt exposes the running sum including this tap.
module mac_unit
  import conv_pkg::*;
#(
  parameter int PIX_W = 8,
  parameter int WGT_W = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    en,
  input  logic [PIX_W-1:0]        pix,
  input  logic signed [WGT_W-1:0] wgt,
  output logic signed [ACC_W-1:0] acc_nxt
);
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  acc_q;

  assign prod    = PROD_W'($signed({1'b0, pix})) * PROD_W'(wgt);
  assign acc_nxt = acc_q + ACC_W'(prod);

  // Clear wins over enable so the final tap of an output can be folded and dropped in one edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)     acc_q <= '0;
    else if (clr) acc_q <= '0;
    else if (en)  acc_q <= acc_nxt;
  end
endmodule

// File: rtl/conv3x3_engine.sv
// 4x4 tile * 3x3 kernel valid convolution on one time-shared MAC; 36 cycles per tile.
module conv3x3_engine
  import conv_pkg::*;
#(
  parameter int PIX_W = 8,
  parameter int WGT_W = 8,
  parameter int RES_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  conv3x3_engine_if.slave    bus
);
  cs_e                          cs_q;
  logic [NUM_PIX*PIX_W-1:0]     pix_q;
  logic [NUM_WGT*WGT_W-1:0]     wgt_q;
  logic [1:0]                   j_q;
  logic [3:0]                   k_q;
  logic signed [SUM_W-1:0]      sum_q;
  logic [31:0]                  shadow_q;
  logic [RES_W-1:0]             ret22_q, ret33_q;

  logic                         accept, busy, out_last;
  logic [3:0]                   idx;
  logic [PIX_W-1:0]             pix_op;
  logic signed [WGT_W-1:0]      wgt_op;
  logic signed [ACC_W-1:0]      o_fin;
  logic [7:0]                   o_byte;
  logic signed [SUM_W-1:0]      sum_nxt;
  logic [31:0]                  shadow_nxt;

  assign accept   = (cs_q == CS_IDLE) && (bus.state == MS_LOAD);
  assign busy     = (cs_q == CS_BUSY);
  assign out_last = (k_q == 4'(NUM_WGT - 1));

  assign idx    = pix_idx(j_q, k_q);
  assign pix_op = pix_q[PIX_W*idx +: PIX_W];
  assign wgt_op = $signed(wgt_q[WGT_W*k_q +: WGT_W]);

  mac_unit #(.PIX_W(PIX_W), .WGT_W(WGT_W)) u_mac (
    .clk     (clk),
    .rst     (rst),
    .clr     (accept || (busy && out_last)),
    .en      (busy),
    .pix     (pix_op),
    .wgt     (wgt_op),
    .acc_nxt (o_fin)
  );

  always_comb begin
    if (o_fin < 0)        o_byte = 8'd0;
    else if (o_fin > 255) o_byte = 8'd255;
    else                  o_byte = o_fin[7:0];
    sum_nxt    = sum_q + SUM_W'(o_fin);
    shadow_nxt = shadow_q;
    shadow_nxt[8*j_q +: 8] = o_byte;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cs_q     <= CS_IDLE;
      pix_q    <= '0;
      wgt_q    <= '0;
      j_q      <= '0;
      k_q      <= '0;
      sum_q    <= '0;
      shadow_q <= '0;
      ret22_q  <= '0;
      ret33_q  <= '0;
    end else begin
      case (cs_q)
        CS_IDLE: if (accept) begin
          pix_q    <= bus.DATA;
          wgt_q    <= bus.FILTER;
          j_q      <= '0;
          k_q      <= '0;
          sum_q    <= '0;
          shadow_q <= '0;
          cs_q     <= CS_BUSY;
        end
        CS_BUSY: begin
          if (out_last) begin
            k_q      <= '0;
            j_q      <= j_q + 2'd1;
            shadow_q <= shadow_nxt;
            sum_q    <= sum_nxt;
            // Last output of the tile: publish with its own byte/term folded in this edge.
            if (j_q == 2'(NUM_OUT - 1)) begin
              ret22_q <= RES_W'(shadow_nxt);
              ret33_q <= RES_W'(sum_nxt);
              cs_q    <= CS_DONE;
            end
          end else begin
            k_q <= k_q + 4'd1;
          end
        end
        CS_DONE: if (bus.state == MS_STORE) cs_q <= CS_IDLE;
        default: cs_q <= CS_IDLE;
      endcase
    end
  end

  assign bus.CS    = cs_q;
  assign bus.ret22 = ret22_q;
  assign bus.ret33 = ret33_q;
endmodule
